mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning: maximum ACCESS cycles awaiting MemAck before the transaction aborts (range 1..255).
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Req0Read, Req0Write  input  1 each  requester 0 (CPU) read/write request, level, held until Done0.
REQ-005 Req0Address, Req0WriteData  input  32 each  requester 0 address and store data.
REQ-006 Req1Read, Req1Write, Req1Address, Req1WriteData  input  1/1/32/32  requester 1 (loader/DMA), same semantics.
REQ-007 Done0, Done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-008 Error  output  1  valid with Done0/Done1; 1 = timed out.
REQ-009 ReadData  output  32  registered read result, valid while Done0 or Done1 is high.
REQ-010 MemAddress, MemWriteData  output  32 each  shared memory address/store data.
REQ-011 MemRead, MemWrite  output  1 each  memory strobes.
REQ-012 MemReadData  input  32  memory read data, sampled on MemAck.
REQ-013 MemAck  input  1  memory completion, valid only in ACCESS.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any pending request, ACCESS->RESP on MemAck or timeout, RESP->IDLE unconditionally.
REQ-015 Pending for requester N = ReqNRead | ReqNWrite; Read and Write both high is treated as a write.
REQ-016 In IDLE, single pending requester is granted; both pending -> round-robin: grant the one not granted last; after reset requester 0 has priority.
REQ-017 On IDLE->ACCESS edge, address, write data, op and grant id are registered; requester inputs are ignored until IDLE.
REQ-018 In ACCESS, MemAddress/MemWriteData drive registered values; exactly one of MemRead/MemWrite is 1.
REQ-019 Outside ACCESS, MemRead = MemWrite = 0, MemAddress = MemWriteData = 0.
REQ-020 An 8-bit wait counter clears on entering ACCESS, increments each ACCESS cycle without MemAck; reaching TIMEOUT with no MemAck -> RESP with Error = 1.
REQ-021 MemAck in the same cycle the counter reaches TIMEOUT counts as success (Error = 0).
REQ-022 In RESP, Done of the granted requester = 1, other Done = 0; ReadData = captured MemReadData for successful reads, 0 for writes and timeouts.
REQ-023 Requesters deassert (or replace) their request at the clock edge ending their Done cycle; arbiter re-samples in IDLE.
REQ-024 Latency: request seen in IDLE at cycle t, MemAck in first ACCESS cycle -> Done at t+2; back-to-back grant no sooner than one IDLE cycle after RESP.
REQ-025 MemAck outside ACCESS is ignored.

Reset
REQ-026 Rst high at any edge, including mid-ACCESS, returns FSM to IDLE, aborts the transaction without Done, and clears all outputs, registers, counter and round-robin pointer (requester 0 next).

Structure
REQ-027 Shared package mem_arb_pkg holds the state enum (IDLE, ACCESS, RESP), requester-id type and default TIMEOUT constant.
REQ-028 One sub-module rr_arbiter2: two pending inputs, last-grant register, one-hot grant output, advance strobe from FSM.

Verification
REQ-029 Req0Read addr 0x100, MemAck first ACCESS cycle with data 0xDEADBEEF -> MemRead one cycle, Done0 at t+2, ReadData 0xDEADBEEF, Error 0.
REQ-030 Req0Write and Req1Write same cycle, repeated -> grants 0,1,0,1; MemWrite carries each requester's address/data; Done pulses alternate.
REQ-031 Req1Read, MemAck never asserted, TIMEOUT=15 -> MemRead 15 cycles, Done1 with Error 1, ReadData 0.
REQ-032 MemAck arriving exactly on cycle TIMEOUT -> Error 0, data captured.
REQ-033 Rst asserted during ACCESS -> next cycle IDLE, MemRead/MemWrite 0, no Done, next simultaneous request grants requester 0.
REQ-034 Req0Read and Req0Write both high, addr 0x20 -> MemWrite 1, MemRead 0, Done0, ReadData 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state enum, the requester-id type and the default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Requester 0 is the CPU, requester 1 is the loader/DMA.
  typedef logic req_id_t;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie it grants the requester that was not granted last.
// The last-grant register only moves when the FSM strobes advance_i.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] pending_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  req_id_t last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    case (pending_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (|pending_i)) begin
      last_d = grant_o[1];
    end
  end

  // Reset pretends requester 1 went last so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a loader onto one memory port: IDLE -> ACCESS -> RESP,
// with a bounded wait for MemAck and a one-cycle Done/Error/ReadData response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0Read,
  input  logic        Req0Write,
  input  logic [31:0] Req0Address,
  input  logic [31:0] Req0WriteData,
  input  logic        Req1Read,
  input  logic        Req1Write,
  input  logic [31:0] Req1Address,
  input  logic [31:0] Req1WriteData,
  output logic        Done0,
  output logic        Done1,
  output logic        Error,
  output logic [31:0] ReadData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData,
  input  logic        MemAck
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  req_id_t     gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [1:0]  pending;
  logic [1:0]  grant;
  logic        advance;

  assign pending = {Req1Read | Req1Write, Req0Read | Req0Write};
  assign advance = (state_q == IDLE) && (|pending);

  rr_arbiter2 u_rr (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .pending_i(pending),
    .advance_i(advance),
    .grant_o  (grant)
  );

  // A request with both Read and Write high is latched as a write.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    err_d   = err_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (advance) begin
          gnt_d   = grant[1];
          addr_d  = grant[1] ? Req1Address   : Req0Address;
          wdata_d = grant[1] ? Req1WriteData : Req0WriteData;
          write_d = grant[1] ? Req1Write     : Req0Write;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (MemAck) begin
          rdata_d = write_q ? 32'd0 : MemReadData;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((cnt_q + 8'd1) == TimeoutLimit) begin
          cnt_d   = cnt_q + 8'd1;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // The memory bus is quiet outside ACCESS; responses only show during RESP.
  assign MemRead      = (state_q == ACCESS) && !write_q;
  assign MemWrite     = (state_q == ACCESS) &&  write_q;
  assign MemAddress   = (state_q == ACCESS) ? addr_q  : 32'd0;
  assign MemWriteData = (state_q == ACCESS) ? wdata_q : 32'd0;
  assign Done0        = (state_q == RESP) && !gnt_q;
  assign Done1        = (state_q == RESP) &&  gnt_q;
  assign Error        = (state_q == RESP) &&  err_q;
  assign ReadData     = (state_q == RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model
// that tracks held requests, the round-robin winner and the expected ack/timeout outcome.
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0Read, Req0Write, Req1Read, Req1Write;
  logic [31:0] Req0Address, Req0WriteData, Req1Address, Req1WriteData;
  logic        Done0, Done1, Error;
  logic [31:0] ReadData, MemAddress, MemWriteData, MemReadData;
  logic        MemRead, MemWrite, MemAck;

  int checks   = 0;
  int failures = 0;

  // Model state: op 0 = none, 1 = read, 2 = write, 3 = read+write (treated as write).
  int          op[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  int          lastG;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0Read(Req0Read), .Req0Write(Req0Write),
    .Req0Address(Req0Address), .Req0WriteData(Req0WriteData),
    .Req1Read(Req1Read), .Req1Write(Req1Write),
    .Req1Address(Req1Address), .Req1WriteData(Req1WriteData),
    .Done0(Done0), .Done1(Done1), .Error(Error), .ReadData(ReadData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemReadData(MemReadData), .MemAck(MemAck)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    Req0Read      = (op[0] == 1) || (op[0] == 3);
    Req0Write     = (op[0] >= 2);
    Req0Address   = addr[0];
    Req0WriteData = wdata[0];
    Req1Read      = (op[1] == 1) || (op[1] == 3);
    Req1Write     = (op[1] >= 2);
    Req1Address   = addr[1];
    Req1WriteData = wdata[1];
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_memRead"},  {31'd0, MemRead},  32'd0);
    checkOutput({tag, "_memWrite"}, {31'd0, MemWrite}, 32'd0);
    checkOutput({tag, "_memAddr"},  MemAddress,        32'd0);
    checkOutput({tag, "_memWdata"}, MemWriteData,      32'd0);
    checkOutput({tag, "_done"},     {30'd0, Done1, Done0}, 32'd0);
  endtask

  task automatic resetDut();
    Rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      op[n] = 0; addr[n] = '0; wdata[n] = '0;
    end
    applyStimulus();
    MemAck = 1'b0;
    MemReadData = '0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    lastG = 1;
  endtask

  // Entered at a negedge of an IDLE cycle with requests already applied;
  // returns at the negedge of the IDLE cycle following the RESP cycle.
  task automatic doTxn(input int ackDelay, input logic [31:0] ackData);
    int  g;
    bit  wr, ok, ended;
    logic [31:0] expAddr, expData;
    if (op[0] != 0 && op[1] != 0) g = (lastG == 0) ? 1 : 0;
    else                          g = (op[0] != 0) ? 0 : 1;
    lastG   = g;
    wr      = (op[g] >= 2);
    expAddr = addr[g];
    expData = wdata[g];
    ok = 0;
    ended = 0;
    for (int k = 1; k <= TO && !ended; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        if (g == 0) begin Req0Address = $urandom; Req0WriteData = $urandom; end
        else        begin Req1Address = $urandom; Req1WriteData = $urandom; end
      end
      checkOutput("accessRead",  {31'd0, MemRead},  {31'd0, !wr});
      checkOutput("accessWrite", {31'd0, MemWrite}, {31'd0, wr});
      checkOutput("accessAddr",  MemAddress,   expAddr);
      checkOutput("accessWdata", MemWriteData, expData);
      checkOutput("accessDone",  {30'd0, Done1, Done0}, 32'd0);
      MemAck      = (k == ackDelay);
      MemReadData = (k == ackDelay) ? ackData : $urandom;
      if (k == ackDelay) begin
        ok = 1;
        ended = 1;
      end else if (k == TO) begin
        ended = 1;
      end
    end
    @(negedge Clk);
    MemAck      = 1'($urandom_range(0, 1));
    MemReadData = $urandom;
    checkOutput("respDone0", {31'd0, Done0}, {31'd0, g == 0});
    checkOutput("respDone1", {31'd0, Done1}, {31'd0, g == 1});
    checkOutput("respError", {31'd0, Error}, {31'd0, !ok});
    checkOutput("respData",  ReadData, (ok && !wr) ? ackData : 32'd0);
    checkOutput("respStrobe", {30'd0, MemWrite, MemRead}, 32'd0);
    op[g] = 0;
    applyStimulus();
    @(negedge Clk);
    checkQuiet("idle");
    MemAck      = 1'($urandom_range(0, 1));
    MemReadData = $urandom;
  endtask

  initial begin
    resetDut();
    checkQuiet("reset");
    checkOutput("reset_error", {31'd0, Error}, 32'd0);
    checkOutput("reset_rdata", ReadData, 32'd0);

    // Single CPU read acked on the first ACCESS cycle.
    op[0] = 1; addr[0] = 32'h100; wdata[0] = 32'h0;
    applyStimulus();
    doTxn(1, 32'hDEADBEEF);

    // Simultaneous writes alternate 0,1,0,1 from a fresh reset.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (op[n] == 0) begin
          op[n] = 2; addr[n] = 32'h1000 * (n + 1) + i; wdata[n] = 32'hA000_0000 + 32'(n * 16 + i);
        end
      end
      applyStimulus();
      doTxn(2, 32'h0);
    end
    op[0] = 0; op[1] = 0;
    applyStimulus();
    resetDut();

    // Loader read that never gets an ack, then an ack on the last allowed cycle.
    op[1] = 1; addr[1] = 32'h400; wdata[1] = 32'h0;
    applyStimulus();
    doTxn(0, 32'h0);
    op[1] = 1; addr[1] = 32'h404;
    applyStimulus();
    doTxn(TO, 32'h1234_5678);

    // Read and Write both high is a write.
    op[0] = 3; addr[0] = 32'h20; wdata[0] = 32'h5555_AAAA;
    applyStimulus();
    doTxn(1, 32'hFFFF_FFFF);

    // Reset in the middle of an ACCESS: no Done, and requester 0 wins the next tie.
    resetDut();
    op[0] = 1; addr[0] = 32'h300;
    applyStimulus();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    op[0] = 0;
    applyStimulus();
    @(negedge Clk);
    checkQuiet("midReset");
    Rst = 1'b0;
    lastG = 1;
    @(negedge Clk);
    checkQuiet("afterReset");
    op[0] = 1; addr[0] = 32'h500; wdata[0] = 32'h0;
    op[1] = 1; addr[1] = 32'h600; wdata[1] = 32'h0;
    applyStimulus();
    doTxn(1, 32'hCAFE_0000);
    doTxn(1, 32'hCAFE_0001);

    // Randomized traffic with held losers, random ack delays and spurious acks.
    for (int i = 0; i < 150; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (op[n] == 0 && $urandom_range(0, 2) != 0) begin
          op[n] = $urandom_range(1, 3); addr[n] = $urandom; wdata[n] = $urandom;
        end
      end
      if (op[0] == 0 && op[1] == 0) begin
        op[0] = $urandom_range(1, 3); addr[0] = $urandom; wdata[0] = $urandom;
      end
      applyStimulus();
      if ($urandom_range(0, 3) == 0) doTxn(TO, $urandom);
      else                           doTxn($urandom_range(0, TO + 2), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
